// File: rtl/maze_mouse_dfs.sv
// maze_mouse_dfs: depth-first maze search over an external 1-bit-per-cell map.
// Marks visited cells, backtracks through dead ends with a move stack and
// replays the solution path on request, one move per cycle.
// Optional build macro MAZE_MOUSE_PATHLEN_EN adds PathLen / ProbeCount outputs.
module maze_mouse_dfs #(
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int MAZE_W      = 16,
  parameter int MAZE_H      = 16,
  parameter int STACK_DEPTH = 256
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  input  logic           Run,
  input  logic [X_W-1:0] startX,
  input  logic [Y_W-1:0] startY,
  input  logic [X_W-1:0] targetX,
  input  logic [Y_W-1:0] targetY,
  input  logic           Din,
  output logic           RD,
  output logic           WR,
  output logic           Dout,
  output logic [X_W-1:0] addrX,
  output logic [Y_W-1:0] addrY,
  output logic [X_W-1:0] poseX,
  output logic [Y_W-1:0] poseY,
  output logic [1:0]     Move,
  output logic           MoveValid,
  output logic           Busy,
  output logic           Done,
  output logic           Fail
`ifdef MAZE_MOUSE_PATHLEN_EN
  ,
  output logic [$clog2(STACK_DEPTH+1)-1:0] PathLen,
  output logic [15:0]                      ProbeCount
`endif
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [X_W-1:0]  X_MAX   = X_W'(MAZE_W - 1);
  localparam logic [Y_W-1:0]  Y_MAX   = Y_W'(MAZE_H - 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_MARK, S_CHECK, S_TRY, S_WAIT, S_BACK, S_DONE, S_PLAY, S_FAIL
  } state_t;

  state_t state, state_next;

  logic [X_W-1:0]  pose_x, nb_x, back_x;
  logic [Y_W-1:0]  pose_y, nb_y, back_y;
  logic [2:0]      dir;
  logic [SP_W-1:0] sp, sp_m1, idx;
  logic [1:0]      stack [STACK_DEPTH];
  logic [1:0]      pop_dir;
  logic            nb_oob, start_oob, start_go, run_go, stack_full, stack_empty;

  assign sp_m1       = sp - SP_W'(1);
  assign pop_dir     = stack[sp_m1[IDX_W-1:0]];
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign start_oob   = (int'(startX) >= MAZE_W) || (int'(startY) >= MAZE_H);
  assign start_go    = Start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign run_go      = Run && !Start && (state == S_DONE) && !stack_empty;

  // Neighbour of the current pose in direction dir; the edge test runs before
  // any arithmetic so coordinates never wrap.
  always_comb begin
    nb_x   = pose_x;
    nb_y   = pose_y;
    nb_oob = 1'b0;
    case (dir[1:0])
      2'd0: begin nb_oob = (pose_y == '0);    nb_y = pose_y - Y_W'(1); end
      2'd1: begin nb_oob = (pose_x == X_MAX); nb_x = pose_x + X_W'(1); end
      2'd2: begin nb_oob = (pose_y == Y_MAX); nb_y = pose_y + Y_W'(1); end
      default: begin nb_oob = (pose_x == '0); nb_x = pose_x - X_W'(1); end
    endcase
  end

  // Cell reached by undoing the move on top of the stack.
  always_comb begin
    back_x = pose_x;
    back_y = pose_y;
    case (pop_dir)
      2'd0:    back_y = pose_y + Y_W'(1);
      2'd1:    back_x = pose_x - X_W'(1);
      2'd2:    back_y = pose_y - Y_W'(1);
      default: back_x = pose_x + X_W'(1);
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_go)    state_next = start_oob ? S_FAIL : S_MARK;
        else if (run_go) state_next = S_PLAY;
      end
      S_MARK:  state_next = S_CHECK;
      S_CHECK: state_next = (pose_x == targetX && pose_y == targetY) ? S_DONE : S_TRY;
      S_TRY: begin
        if (dir[2])       state_next = S_BACK;
        else if (!nb_oob) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!Din)             state_next = stack_full ? S_FAIL : S_MARK;
        else if (dir == 3'd3) state_next = S_BACK;
        else                  state_next = S_TRY;
      end
      S_BACK: begin
        if (stack_empty)          state_next = S_FAIL;
        else if (pop_dir != 2'd3) state_next = S_TRY;
      end
      S_PLAY:  state_next = (idx == sp_m1) ? S_DONE : S_PLAY;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    RD        = 1'b0;
    WR        = 1'b0;
    Dout      = 1'b0;
    addrX     = '0;
    addrY     = '0;
    Move      = '0;
    MoveValid = 1'b0;
    Busy      = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    Done      = (state == S_DONE);
    Fail      = (state == S_FAIL);
    case (state)
      S_MARK: begin
        WR    = 1'b1;
        Dout  = 1'b1;
        addrX = pose_x;
        addrY = pose_y;
      end
      S_TRY: begin
        if (!dir[2] && !nb_oob) begin
          RD    = 1'b1;
          addrX = nb_x;
          addrY = nb_y;
        end
      end
      S_WAIT: begin
        addrX = nb_x;
        addrY = nb_y;
      end
      S_PLAY: begin
        MoveValid = 1'b1;
        Move      = stack[idx[IDX_W-1:0]];
      end
      default: ;
    endcase
  end

  assign poseX = pose_x;
  assign poseY = pose_y;

  // Pose, direction, stack pointer and replay index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pose_x <= '0;
      pose_y <= '0;
      dir    <= '0;
      sp     <= '0;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_go) begin
            sp  <= '0;
            dir <= '0;
            if (!start_oob) begin
              pose_x <= startX;
              pose_y <= startY;
            end
          end else if (run_go) begin
            idx <= '0;
          end
        end
        S_CHECK: dir <= '0;
        S_TRY: begin
          if (!dir[2] && nb_oob) dir <= dir + 3'd1;
        end
        S_WAIT: begin
          if (!Din) begin
            if (!stack_full) begin
              sp     <= sp + SP_W'(1);
              pose_x <= nb_x;
              pose_y <= nb_y;
            end
          end else begin
            dir <= dir + 3'd1;
          end
        end
        S_BACK: begin
          if (!stack_empty) begin
            sp     <= sp_m1;
            pose_x <= back_x;
            pose_y <= back_y;
            if (pop_dir != 2'd3) dir <= {1'b0, pop_dir} + 3'd1;
          end
        end
        S_PLAY: idx <= idx + SP_W'(1);
        default: ;
      endcase
    end
  end

  // Move stack storage; written only on a successful push.
  always_ff @(posedge CLK) begin
    if (state == S_WAIT && !Din && !stack_full) stack[sp[IDX_W-1:0]] <= dir[1:0];
  end

`ifdef MAZE_MOUSE_PATHLEN_EN
  logic [15:0] probe_cnt;

  // Saturating count of map read strobes since the last accepted Start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                         probe_cnt <= '0;
    else if (start_go)                probe_cnt <= '0;
    else if (RD && (probe_cnt != '1)) probe_cnt <= probe_cnt + 16'd1;
  end

  assign PathLen    = sp;
  assign ProbeCount = probe_cnt;
`else
  // Path statistics outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_maze_mouse_dfs.sv
// Directed bench for maze_mouse_dfs: a 16x16 instance (depth 256) and a 4x4
// instance (depth 2), each with its own behavioural map memory.
module tb_maze_mouse_dfs;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic       start_a, run_a, din_a, rd_a, wr_a, dout_a, mv_a, busy_a, done_a, fail_a;
  logic [3:0] sx_a, sy_a, tx_a, ty_a, ax_a, ay_a, px_a, py_a;
  logic [1:0] move_a;
  logic       start_b, run_b, din_b, rd_b, wr_b, dout_b, mv_b, busy_b, done_b, fail_b;
  logic [3:0] sx_b, sy_b, tx_b, ty_b, ax_b, ay_b, px_b, py_b;
  logic [1:0] move_b;
`ifdef MAZE_MOUSE_PATHLEN_EN
  logic [8:0]  pl_a;
  logic [15:0] pc_a;
  logic [1:0]  pl_b;
  logic [15:0] pc_b;
`endif

  maze_mouse_dfs #(.X_W(4), .Y_W(4), .MAZE_W(16), .MAZE_H(16), .STACK_DEPTH(256)) u_a (
    .CLK(CLK), .RST(RST), .Start(start_a), .Run(run_a),
    .startX(sx_a), .startY(sy_a), .targetX(tx_a), .targetY(ty_a),
    .Din(din_a), .RD(rd_a), .WR(wr_a), .Dout(dout_a),
    .addrX(ax_a), .addrY(ay_a), .poseX(px_a), .poseY(py_a),
    .Move(move_a), .MoveValid(mv_a), .Busy(busy_a), .Done(done_a), .Fail(fail_a)
`ifdef MAZE_MOUSE_PATHLEN_EN
    , .PathLen(pl_a), .ProbeCount(pc_a)
`endif
  );

  maze_mouse_dfs #(.X_W(4), .Y_W(4), .MAZE_W(4), .MAZE_H(4), .STACK_DEPTH(2)) u_b (
    .CLK(CLK), .RST(RST), .Start(start_b), .Run(run_b),
    .startX(sx_b), .startY(sy_b), .targetX(tx_b), .targetY(ty_b),
    .Din(din_b), .RD(rd_b), .WR(wr_b), .Dout(dout_b),
    .addrX(ax_b), .addrY(ay_b), .poseX(px_b), .poseY(py_b),
    .Move(move_b), .MoveValid(mv_b), .Busy(busy_b), .Done(done_b), .Fail(fail_b)
`ifdef MAZE_MOUSE_PATHLEN_EN
    , .PathLen(pl_b), .ProbeCount(pc_b)
`endif
  );

  // Map memories, indexed [y][x]; combinational read, write on the clock edge.
  bit map_a [16][16];
  bit map_b [16][16];
  int wr_cnt_a, wr_cnt_b;
  logic       cfg_clear, cfg_fill, cfg_set, cfg_sel, cfg_val;
  logic [3:0] cfg_x, cfg_y;

  assign din_a = map_a[ay_a][ax_a];
  assign din_b = map_b[ay_b][ax_b];

  always @(posedge CLK) begin
    if (cfg_clear) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) begin
          map_a[y][x] <= cfg_fill;
          map_b[y][x] <= cfg_fill;
        end
      wr_cnt_a <= 0;
      wr_cnt_b <= 0;
    end else begin
      if (cfg_set) begin
        if (cfg_sel) map_b[cfg_y][cfg_x] <= cfg_val;
        else         map_a[cfg_y][cfg_x] <= cfg_val;
      end
      if (wr_a) begin
        map_a[ay_a][ax_a] <= dout_a;
        wr_cnt_a <= wr_cnt_a + 1;
      end
      if (wr_b) begin
        map_b[ay_b][ax_b] <= dout_b;
        wr_cnt_b <= wr_cnt_b + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic map_fill(input bit val);
    @(negedge CLK);
    cfg_clear = 1'b1;
    cfg_fill  = val;
    @(negedge CLK);
    cfg_clear = 1'b0;
  endtask

  task automatic map_set(input bit sel, input int x, input int y, input bit val);
    @(negedge CLK);
    cfg_set = 1'b1;
    cfg_sel = sel;
    cfg_x   = 4'(x);
    cfg_y   = 4'(y);
    cfg_val = val;
    @(negedge CLK);
    cfg_set = 1'b0;
  endtask

  // Raise Start at a falling edge; the next rising edge samples it.
  task automatic go(input bit sel, input int sx, input int sy, input int tx, input int ty);
    @(negedge CLK);
    if (sel) begin
      sx_b = 4'(sx); sy_b = 4'(sy); tx_b = 4'(tx); ty_b = 4'(ty); start_b = 1'b1;
    end else begin
      sx_a = 4'(sx); sy_a = 4'(sy); tx_a = 4'(tx); ty_a = 4'(ty); start_a = 1'b1;
    end
  endtask

  task automatic wait_end(input bit sel, input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge CLK);
      start_a = 1'b0;
      start_b = 1'b0;
      cyc++;
      if (sel ? (done_b || fail_b) : (done_a || fail_a)) break;
    end
  endtask

  int         n_moves;
  logic [1:0] moves [16];
  logic       replay_busy, pose_moved;

  task automatic replay(input bit sel);
    logic [7:0] pose0;
    n_moves    = 0;
    pose_moved = 1'b0;
    @(negedge CLK);
    pose0 = sel ? {px_b, py_b} : {px_a, py_a};
    if (sel) run_b = 1'b1; else run_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      run_a = 1'b0;
      run_b = 1'b0;
      if (i == 0) replay_busy = sel ? busy_b : busy_a;
      if ((sel ? {px_b, py_b} : {px_a, py_a}) != pose0) pose_moved = 1'b1;
      if (sel ? mv_b : mv_a) begin
        if (n_moves < 16) moves[n_moves] = sel ? move_b : move_a;
        n_moves++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int cyc;

  initial begin
    RST = 1'b1;
    start_a = 0; run_a = 0; sx_a = 0; sy_a = 0; tx_a = 0; ty_a = 0;
    start_b = 0; run_b = 0; sx_b = 0; sy_b = 0; tx_b = 0; ty_b = 0;
    cfg_clear = 0; cfg_fill = 0; cfg_set = 0; cfg_sel = 0; cfg_val = 0; cfg_x = 0; cfg_y = 0;
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_fail", fail_a, 0);
    check("rst_strobes", {rd_a, wr_a, mv_a}, 0);
    check("rst_pose", {px_a, py_a}, 0);
    check("rst_addr", {ax_a, ay_a}, 0);
    check("rst_b_busy", {busy_b, done_b, fail_b}, 0);
    map_fill(1'b0);
    @(negedge CLK);
    RST = 1'b1;

    // Start equals target on the 4x4 instance.
    map_fill(1'b0);
    go(1'b1, 2, 2, 2, 2);
    @(negedge CLK); start_b = 1'b0;
    check("t1_mark_wr", wr_b, 1);
    check("t1_mark_addr", {ax_b, ay_b}, 8'h22);
    check("t1_busy", busy_b, 1);
    @(negedge CLK);
    check("t1_done_early", done_b, 0);
    @(negedge CLK);
    check("t1_done", done_b, 1);
    check("t1_idle_busy", busy_b, 0);
    check("t1_wr_cnt", wr_cnt_b, 1);
    check("t1_marked", map_b[2][2], 1);
`ifdef MAZE_MOUSE_PATHLEN_EN
    check("t1_pathlen", pl_b, 0);
`endif
    replay(1'b1);
    check("t1_run_moves", n_moves, 0);
    check("t1_run_done", done_b, 1);

    // Out-of-bounds start from DONE goes straight to FAIL.
    map_fill(1'b0);
    go(1'b1, 4, 0, 0, 0);
    @(negedge CLK); start_b = 1'b0;
    check("t6_oob_fail", fail_b, 1);
    check("t6_oob_done", done_b, 0);
    check("t6_oob_wr", wr_cnt_b, 0);

    // Stack overflow: depth 2, open row 0, target unreachable.
    map_fill(1'b1);
    map_set(1'b1, 1, 0, 1'b0);
    map_set(1'b1, 2, 0, 1'b0);
    map_set(1'b1, 3, 0, 1'b0);
    go(1'b1, 0, 0, 5, 0);
    wait_end(1'b1, 100, cyc);
    check("t5_fail", fail_b, 1);
    check("t5_pose", {px_b, py_b}, 8'h20);
    check("t5_wr_cnt", wr_cnt_b, 3);
`ifdef MAZE_MOUSE_PATHLEN_EN
    check("t5_pathlen", pl_b, 2);
    check("t5_probes", pc_b, 3);
`endif

    // Open 16x16 map, straight run to the right.
    map_fill(1'b0);
    go(1'b0, 0, 0, 3, 0);
    wait_end(1'b0, 100, cyc);
    check("t2_done", done_a, 1);
    check("t2_cycles", cyc, 18);
    check("t2_pose", {px_a, py_a}, 8'h30);
    check("t2_wr_cnt", wr_cnt_a, 4);
    replay(1'b0);
    check("t2_n_moves", n_moves, 3);
    check("t2_moves", {moves[0], moves[1], moves[2]}, 6'b01_01_01);
    check("t2_play_busy", replay_busy, 1);
    check("t2_pose_still", pose_moved, 0);
    check("t2_back_done", done_a, 1);

    // Pocket of three cells, walled target: exhaust and fail.
    map_fill(1'b1);
    map_set(1'b0, 0, 0, 1'b0);
    map_set(1'b0, 1, 0, 1'b0);
    map_set(1'b0, 0, 1, 1'b0);
    go(1'b0, 0, 0, 5, 5);
    wait_end(1'b0, 200, cyc);
    check("t3_fail", fail_a, 1);
    check("t3_done", done_a, 0);
    check("t3_pose", {px_a, py_a}, 8'h00);
    check("t3_wr_cnt", wr_cnt_a, 3);
    check("t3_marks", {map_a[0][1], map_a[1][0]}, 2'b11);
    map_fill(1'b0);
    go(1'b0, 0, 0, 0, 0);
    @(negedge CLK); start_a = 1'b0;
    check("t3_fail_clr", fail_a, 0);
    @(negedge CLK);
    @(negedge CLK);
    check("t3_restart_done", done_a, 1);

    // Dead end to the right, real exit downwards.
    map_fill(1'b1);
    map_set(1'b0, 1, 0, 1'b0);
    map_set(1'b0, 0, 1, 1'b0);
    map_set(1'b0, 0, 2, 1'b0);
    map_set(1'b0, 0, 3, 1'b0);
    go(1'b0, 0, 0, 0, 3);
    wait_end(1'b0, 200, cyc);
    check("t4_done", done_a, 1);
    check("t4_pose", {px_a, py_a}, 8'h03);
    check("t4_wr_cnt", wr_cnt_a, 5);
    replay(1'b0);
    check("t4_n_moves", n_moves, 3);
    check("t4_moves", {moves[0], moves[1], moves[2]}, 6'b10_10_10);
    // Start and Run together in DONE: Start wins.
    @(negedge CLK);
    sx_a = 0; sy_a = 3; tx_a = 0; ty_a = 3;
    start_a = 1'b1; run_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0; run_a = 1'b0;
    check("t4_sr_mv", mv_a, 0);
    check("t4_sr_wr", wr_a, 1);
    wait_end(1'b0, 10, cyc);
    check("t4_sr_done", done_a, 1);

    // Asynchronous reset while waiting on a map read.
    map_fill(1'b0);
    go(1'b0, 0, 0, 3, 0);
    repeat (10) begin
      @(negedge CLK);
      start_a = 1'b0;
    end
    check("t7_wait_addr", {ax_a, ay_a}, 8'h20);
    check("t7_wait_pose", {px_a, py_a}, 8'h10);
    #2 RST = 1'b0;
    #1;
    check("t7_rst_pose", {px_a, py_a}, 0);
    check("t7_rst_busy", busy_a, 0);
    check("t7_rst_addr", {ax_a, ay_a}, 0);
    @(negedge CLK);
    RST = 1'b1;
    map_fill(1'b0);
    go(1'b0, 2, 2, 2, 0);
    wait_end(1'b0, 100, cyc);
    check("t7_done", done_a, 1);
    check("t7_pose", {px_a, py_a}, 8'h20);
    replay(1'b0);
    check("t7_n_moves", n_moves, 2);
    check("t7_moves", {moves[0], moves[1]}, 4'b00_00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maze_mouse_dfs.md
Name: maze_mouse_dfs

Overview:
- Parametrised successor to the team's fixed 16x16 intelligent-mouse solver.
- Performs a depth-first maze search over an external 1-bit-per-cell map memory, with a configurable rectangular maze size, runtime start/target coordinates and a parametrised move stack.
- Marks visited cells in the map and backtracks through dead ends.
- After success, replays the solution path on request, one move per cycle.
- Sits between the top-level control (Start/Run) and the map RAM.

Parameters:
- X_W, 4, bit width of X coordinate.
- Y_W, 4, bit width of Y coordinate.
- MAZE_W, 16, number of columns; must satisfy 1 <= MAZE_W <= 2^X_W.
- MAZE_H, 16, number of rows; must satisfy 1 <= MAZE_H <= 2^Y_W.
- STACK_DEPTH, 256, maximum path length in moves; must be >= 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  begin search; sampled in IDLE/DONE/FAIL only.
- Run  in  1  start path replay; sampled in DONE only.
- startX  in  X_W  start column.
- startY  in  Y_W  start row.
- targetX  in  X_W  target column.
- targetY  in  Y_W  target row.
- Din  in  1  map read data: 1 = wall/visited, 0 = free.
- RD  out  1  map read strobe.
- WR  out  1  map write strobe.
- Dout  out  1  map write data.
- addrX  out  X_W  map access column.
- addrY  out  Y_W  map access row.
- poseX  out  X_W  current mouse column.
- poseY  out  Y_W  current mouse row.
- Move  out  2  replay move: 0 = up (Y-1), 1 = right (X+1), 2 = down (Y+1), 3 = left (X-1).
- MoveValid  out  1  Move is valid this cycle.
- Busy  out  1  search or replay in progress.
- Done  out  1  target reached; held.
- Fail  out  1  no path, or stack overflow; held.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including poseX/poseY.
  - Stack pointer is cleared and direction register is 0.
- Map memory timing:
  - Combinational read: Din is sampled the cycle after RD=1, with addrX/addrY held.
  - Write takes effect on the clock edge where WR=1.
- States:
  - IDLE: on Start=1, load pose=start, clear stack pointer, set dir=0, go to MARK.
  - MARK (1 cycle): WR=1, Dout=1, addr=pose. Go to CHECK.
  - CHECK: if pose==target, go to DONE. Otherwise set dir=0 and go to TRY.
  - TRY: compute the neighbour in direction dir.
    - If the neighbour is outside [0,MAZE_W-1] x [0,MAZE_H-1], advance dir without a memory access.
    - Otherwise RD=1, addr=neighbour, go to WAIT.
    - If dir exceeds 3, go to BACK.
  - WAIT: sample Din.
    - If Din=0 and the stack is full, go to FAIL.
    - If Din=0 and the stack is not full, push dir, pose=neighbour, go to MARK.
    - If Din=1, dir++ and go to TRY; if dir was 3, go to BACK.
  - BACK:
    - If the stack is empty, go to FAIL.
    - Otherwise pop d and move pose opposite to d.
    - If d==3, stay in BACK; else set dir=d+1 and go to TRY.
  - DONE: Done=1.
    - Run=1 starts replay: go to PLAY with replay index=0.
    - Start=1 restarts the search as from IDLE and clears Done.
  - PLAY: each cycle drive MoveValid=1 and Move=stack[idx], then idx++.
    - After entry sp-1, return to DONE.
    - An empty path (sp=0) returns to DONE immediately with no MoveValid.
    - The stack and pose are unchanged by replay.
  - FAIL: Fail=1, held. Start=1 restarts the search as from IDLE and clears Fail.
- Busy=1 in every state except IDLE, DONE and FAIL.
- Ignored inputs:
  - Start is ignored while Busy=1.
  - Run is ignored outside DONE.
  - Simultaneous Start and Run in DONE: Start wins.
- Start cell: the start cell is never read; it is marked visited unconditionally.
- Boundary rules:
  - Coordinate arithmetic never wraps; bounds are checked before the access.
  - When the start is out of bounds, go to FAIL directly from IDLE on Start.
- Probe cost: each probe takes 2 cycles (TRY + WAIT); an out-of-bounds skip takes 1 cycle.
- Map contents: the block never clears visited marks; the testbench or system reloads the map between searches.

Optional Feature:
- Macro: MAZE_MOUSE_PATHLEN_EN.
- Defined:
  - Adds output PathLen, width clog2(STACK_DEPTH+1), equal to the stack pointer.
  - Adds output ProbeCount (16 bits, saturating), counting RD strobes since Start.
  - Both reset to 0 and are cleared on Start.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Empty 4x4 map (MAZE_W=MAZE_H=4), start=target=(2,2) -> one WR at (2,2); Done=1 three cycles after Start; Run gives no MoveValid.
- Empty 16x16 map, start (0,0), target (3,0) -> up is skipped as out of bounds; pushes right x3; Done. Run -> MoveValid for 3 cycles with Move=1,1,1; poseX stays 3.
- Target (5,5) fully walled, start (0,0) in a 3-cell pocket -> all cells marked; Fail=1; pose returns to (0,0); Start again restarts.
- Corridor (0,0)->(1,0) dead end with the exit at (0,1): right is taken first, then backtrack via left pop -> final replay Move=2,... to target (0,3) gives 2,2,2.
- STACK_DEPTH=2, open row, target (5,0) -> Fail on the third push attempt; PathLen=2 with MAZE_MOUSE_PATHLEN_EN.
- RST low mid-WAIT -> outputs 0 immediately (async); after release, Start with new coordinates completes normally.
